line_buf_ctrl: RTL

LINE_BUF_CTRL -- requirements
Module: line_buf_ctrl

---
 rtl/line_buf_ctrl.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/line_buf_ctrl.sv
// Ping-pong line buffer controller: fills one bank per line while the other drains.
// Optional LBC_DROP_COUNT_EN adds a saturating 16-bit count of discarded lines.
module line_buf_ctrl #(
   parameter int DEPTH  = 65,
   parameter int ADDR_W = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              ls,
   input  logic              le,
   input  logic              pix_valid,
   input  logic [7:0]        pix_data,
   output logic              wr_en,
   output logic              wr_bank,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [7:0]        wr_data,
   input  logic              rd_ready,
   output logic              rd_valid,
   output logic              rd_bank,
   output logic [ADDR_W-1:0] rd_addr,
   output logic              rd_last,
   output logic [1:0]        bank_full,
   output logic              drop_line
`ifdef LBC_DROP_COUNT_EN
   ,
   output logic [15:0]       drop_count
`endif
);

   typedef enum logic [1:0] {W_IDLE, W_FILL, W_DROP} w_state_t;
   typedef enum logic {R_IDLE, R_DRAIN} r_state_t;

   localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);
   localparam logic [ADDR_W-1:0] ONE_A   = ADDR_W'(1);

   w_state_t          w_state;
   r_state_t          r_state;
   logic              wsel;
   logic              rsel;
   logic [ADDR_W-1:0] count;
   logic [ADDR_W-1:0] len [2];
   logic              wr_ok;
   logic              line_done;
   logic              rd_accept;
   logic              rd_done;
   logic [1:0]        set_mask;
   logic [1:0]        clr_mask;

   // A line-start or line-end cycle never writes; ls restarts and le closes the line.
   assign wr_ok     = (w_state == W_FILL) && !ls && !le && pix_valid && (count < DEPTH_A);
   assign wr_en     = wr_ok;
   assign wr_bank   = wsel;
   assign wr_addr   = count;
   assign wr_data   = wr_ok ? pix_data : 8'h00;
   assign line_done = (w_state == W_FILL) && le && (count != '0);

   assign rd_valid  = (r_state == R_DRAIN);
   assign rd_bank   = rsel;
   assign rd_last   = rd_valid && (rd_addr == len[rsel] - ONE_A);
   assign rd_accept = rd_valid && rd_ready;
   assign rd_done   = rd_accept && rd_last;

   always_comb begin
      set_mask = 2'b00;
      clr_mask = 2'b00;
      if (line_done) set_mask[wsel] = 1'b1;
      if (rd_done)   clr_mask[rsel] = 1'b1;
   end

   // Write side: a line only lands in a free bank, otherwise it is dropped whole.
   always_ff @(posedge clk) begin
      if (reset) begin
         w_state   <= W_IDLE;
         wsel      <= 1'b0;
         count     <= '0;
         drop_line <= 1'b0;
         len[0]    <= '0;
         len[1]    <= '0;
      end else begin
         drop_line <= 1'b0;
         case (w_state)
            W_IDLE: begin
               if (ls) begin
                  if (!bank_full[wsel]) begin
                     w_state <= W_FILL;
                     count   <= '0;
                  end else begin
                     w_state   <= W_DROP;
                     drop_line <= 1'b1;
                  end
               end
            end
            W_FILL: begin
               if (le) begin
                  if (count != '0) begin
                     len[wsel] <= count;
                     wsel      <= ~wsel;
                  end
                  w_state <= W_IDLE;
               end else if (ls) begin
                  count <= '0;
               end else if (wr_ok) begin
                  count <= count + ONE_A;
               end
            end
            W_DROP: begin
               if (le) w_state <= W_IDLE;
            end
            default: w_state <= W_IDLE;
         endcase
      end
   end

   // Read side plus the shared full flags, which both sides may touch in one cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= R_IDLE;
         rsel      <= 1'b0;
         rd_addr   <= '0;
         bank_full <= 2'b00;
      end else begin
         bank_full <= (bank_full & ~clr_mask) | set_mask;
         case (r_state)
            R_IDLE: begin
               if (bank_full[rsel]) begin
                  r_state <= R_DRAIN;
                  rd_addr <= '0;
               end
            end
            R_DRAIN: begin
               if (rd_accept) begin
                  if (rd_last) begin
                     r_state <= R_IDLE;
                     rsel    <= ~rsel;
                     rd_addr <= '0;
                  end else begin
                     rd_addr <= rd_addr + ONE_A;
                  end
               end
            end
            default: r_state <= R_IDLE;
         endcase
      end
   end

`ifdef LBC_DROP_COUNT_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         drop_count <= 16'h0000;
      end else if (drop_line && (drop_count != 16'hFFFF)) begin
         drop_count <= drop_count + 16'h0001;
      end
   end
`endif

endmodule
